// File: rtl/pipe_stall_ctrl.sv
// Stall/bubble controller for the 5-stage pipeline: Tuse/Tnew register hazards
// plus the busy/done sequencing of the multi-cycle mult/div unit.
module pipe_stall_ctrl #(
  parameter int unsigned MULT_CYC = 5,
  parameter int unsigned DIV_CYC  = 10
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [4:0] d_rs_addr,
  input  logic [4:0] d_rt_addr,
  input  logic [1:0] d_rs_tuse,
  input  logic [1:0] d_rt_tuse,
  input  logic       d_is_md,
  input  logic [4:0] e_wa,
  input  logic [1:0] e_tnew,
  input  logic [4:0] m_wa,
  input  logic [1:0] m_tnew,
  input  logic       e_md_start,
  input  logic [1:0] e_md_op,
  output logic       stall,
  output logic       pc_en,
  output logic       fd_en,
  output logic       de_clr,
  output logic       md_busy,
  output logic       md_done
);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } md_state_e;

  localparam logic [3:0] MULT_LAT = 4'(MULT_CYC);
  localparam logic [3:0] DIV_LAT  = 4'(DIV_CYC);

  md_state_e  state_q;
  logic [3:0] cnt_q;
  logic       md_busy_q;
  logic       md_done_q;

  logic       rs_stall_s;
  logic       rt_stall_s;
  logic       md_stall_s;
  logic       stall_s;
  logic       md_op_unused_s;

  // A source stalls only if a producer still needs more cycles than the consumer can wait.
  function automatic logic src_hazard(
    input logic [4:0] addr,
    input logic [1:0] tuse,
    input logic [4:0] ewa,
    input logic [1:0] etnew,
    input logic [4:0] mwa,
    input logic [1:0] mtnew
  );
    logic e_hit;
    logic m_hit;
    e_hit = (addr == ewa) && (etnew > tuse);
    m_hit = (addr == mwa) && (mtnew > tuse);
    return (addr != 5'd0) && (e_hit || m_hit);
  endfunction

  // Combine register and mult/div hazards into the single pipeline stall
  always_comb begin
    rs_stall_s = src_hazard(d_rs_addr, d_rs_tuse, e_wa, e_tnew, m_wa, m_tnew);
    rt_stall_s = src_hazard(d_rt_addr, d_rt_tuse, e_wa, e_tnew, m_wa, m_tnew);
    md_stall_s = d_is_md && (e_md_start || md_busy_q);
    stall_s    = rs_stall_s || rt_stall_s || md_stall_s;
  end

  // Only the div/mult distinction matters for latency; signedness is the unit's concern.
  assign md_op_unused_s = e_md_op[0];

  // Mult/div busy counter: load on start, count down, pulse done on the last busy cycle's edge
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      cnt_q     <= 4'd0;
      md_busy_q <= 1'b0;
      md_done_q <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          md_done_q <= 1'b0;
          if (e_md_start) begin
            state_q   <= ST_BUSY;
            cnt_q     <= e_md_op[1] ? DIV_LAT : MULT_LAT;
            md_busy_q <= 1'b1;
          end else begin
            state_q   <= ST_IDLE;
            cnt_q     <= 4'd0;
            md_busy_q <= 1'b0;
          end
        end
        ST_BUSY: begin
          // A start while busy is ignored; <= 1 also recovers from a corrupted zero count
          if (cnt_q <= 4'd1) begin
            state_q   <= ST_IDLE;
            cnt_q     <= 4'd0;
            md_busy_q <= 1'b0;
            md_done_q <= 1'b1;
          end else begin
            state_q   <= ST_BUSY;
            cnt_q     <= cnt_q - 4'd1;
            md_busy_q <= 1'b1;
            md_done_q <= 1'b0;
          end
        end
        default: begin
          state_q   <= ST_IDLE;
          cnt_q     <= 4'd0;
          md_busy_q <= 1'b0;
          md_done_q <= 1'b0;
        end
      endcase
    end
  end

  assign stall   = stall_s;
  assign pc_en   = ~stall_s;
  assign fd_en   = ~stall_s;
  assign de_clr  = stall_s;
  assign md_busy = md_busy_q;
  assign md_done = md_done_q;

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// Directed and randomized check of pipe_stall_ctrl against a cycle-indexed
// reference model of the hazard rules and mult/div busy windows.
module tb_pipe_stall_ctrl;

  localparam int MULT_LAT = 5;
  localparam int DIV_LAT  = 10;

  logic       clk;
  logic       rst;
  logic [4:0] d_rs_addr;
  logic [4:0] d_rt_addr;
  logic [1:0] d_rs_tuse;
  logic [1:0] d_rt_tuse;
  logic       d_is_md;
  logic [4:0] e_wa;
  logic [1:0] e_tnew;
  logic [4:0] m_wa;
  logic [1:0] m_tnew;
  logic       e_md_start;
  logic [1:0] e_md_op;
  logic       stall;
  logic       pc_en;
  logic       fd_en;
  logic       de_clr;
  logic       md_busy;
  logic       md_done;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  // Model: the unit is busy in cycles [busy_lo, busy_hi] and signals done in cycle done_c
  int busy_lo = 1;
  int busy_hi = 0;
  int done_c  = -1;

  pipe_stall_ctrl #(.MULT_CYC(MULT_LAT), .DIV_CYC(DIV_LAT)) dut (
    .clk(clk), .rst(rst),
    .d_rs_addr(d_rs_addr), .d_rt_addr(d_rt_addr),
    .d_rs_tuse(d_rs_tuse), .d_rt_tuse(d_rt_tuse), .d_is_md(d_is_md),
    .e_wa(e_wa), .e_tnew(e_tnew), .m_wa(m_wa), .m_tnew(m_tnew),
    .e_md_start(e_md_start), .e_md_op(e_md_op),
    .stall(stall), .pc_en(pc_en), .fd_en(fd_en), .de_clr(de_clr),
    .md_busy(md_busy), .md_done(md_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // The stimulus must never start a mult/div while the unit reports busy
  always @(negedge clk) begin
    if (!rst && e_md_start === 1'b1) begin
      tests++;
      assert (md_busy !== 1'b1) else begin
        fails++;
        $error("FAIL illegal_md_start: md_busy=%b required 0 at cycle %0d", md_busy, cyc);
      end
    end
  end

  function automatic bit m_busy(input int c);
    return (c >= busy_lo) && (c <= busy_hi);
  endfunction

  // Operand waits iff some in-flight writer of that register is ready later than it is needed
  function automatic bit operand_waits(input int addr, input int tuse);
    int need_ready;
    need_ready = 0;
    if (addr != 0 && addr == int'(e_wa) && int'(e_tnew) > need_ready) need_ready = int'(e_tnew);
    if (addr != 0 && addr == int'(m_wa) && int'(m_tnew) > need_ready) need_ready = int'(m_tnew);
    return need_ready > tuse;
  endfunction

  function automatic bit m_stall();
    bit reg_wait;
    bit md_wait;
    reg_wait = operand_waits(int'(d_rs_addr), int'(d_rs_tuse)) ||
               operand_waits(int'(d_rt_addr), int'(d_rt_tuse));
    md_wait  = d_is_md && (e_md_start || m_busy(cyc));
    return reg_wait || md_wait;
  endfunction

  task automatic chk(input string tag, input logic obs, input logic exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %b expected %b at cycle %0d", tag, obs, exp, cyc);
    end
  endtask

  task automatic idle_inputs();
    d_rs_addr  = 5'd0;  d_rt_addr = 5'd0;
    d_rs_tuse  = 2'd3;  d_rt_tuse = 2'd3;
    d_is_md    = 1'b0;
    e_wa       = 5'd0;  e_tnew    = 2'd0;
    m_wa       = 5'd0;  m_tnew    = 2'd0;
    e_md_start = 1'b0;  e_md_op   = 2'b00;
  endtask

  // Check all outputs for the current cycle, then advance the model across the edge
  task automatic step();
    bit s;
    @(negedge clk);
    s = m_stall();
    chk("stall",   stall,   s);
    chk("pc_en",   pc_en,   !s);
    chk("fd_en",   fd_en,   !s);
    chk("de_clr",  de_clr,  s);
    chk("md_busy", md_busy, m_busy(cyc));
    chk("md_done", md_done, cyc == done_c);
    @(posedge clk);
    if (rst) begin
      busy_lo = 1; busy_hi = 0; done_c = -1;
    end else if (e_md_start && !m_busy(cyc)) begin
      busy_lo = cyc + 1;
      busy_hi = cyc + (e_md_op[1] ? DIV_LAT : MULT_LAT);
      done_c  = busy_hi + 1;
    end
    cyc++;
    #1;
  endtask

  initial begin
    int k;
    int guard;
    rst = 1'b1;
    idle_inputs();
    @(posedge clk);
    #1;
    step();
    step();
    rst = 1'b0;
    step();

    // Load-use: lw $1 in E, consumer needs rs next cycle
    e_wa = 5'd1; e_tnew = 2'd2; d_rs_addr = 5'd1; d_rs_tuse = 2'd1;
    step();
    e_wa = 5'd0; e_tnew = 2'd0; m_wa = 5'd1; m_tnew = 2'd1;
    step();
    // $0 never stalls; Tuse=3 never stalls; rt hazard from M does
    idle_inputs();
    e_tnew = 2'd2; d_rs_tuse = 2'd0;
    step();
    e_wa = 5'd5; d_rt_addr = 5'd5; d_rt_tuse = 2'd3;
    step();
    d_rt_tuse = 2'd1;
    step();
    idle_inputs();
    m_wa = 5'd7; m_tnew = 2'd2; d_rt_addr = 5'd7; d_rt_tuse = 2'd1;
    step();

    // mult with a mult/div instruction waiting in D throughout
    idle_inputs();
    d_is_md = 1'b1; e_md_start = 1'b1; e_md_op = 2'b00;
    step();
    e_md_start = 1'b0;
    for (int i = 0; i < 8; i++) step();

    // div with an unrelated instruction in D, plus a simultaneous register hazard partway
    idle_inputs();
    e_md_start = 1'b1; e_md_op = 2'b10;
    step();
    e_md_start = 1'b0;
    for (int i = 0; i < 12; i++) begin
      if (i == 4) begin d_is_md = 1'b1; e_wa = 5'd3; e_tnew = 2'd1; d_rs_addr = 5'd3; d_rs_tuse = 2'd0; end
      else idle_inputs();
      step();
    end

    // Reset in the 4th busy cycle of a div aborts it
    idle_inputs();
    e_md_start = 1'b1; e_md_op = 2'b11;
    step();
    e_md_start = 1'b0; d_is_md = 1'b1;
    for (int i = 0; i < 3; i++) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    for (int i = 0; i < 12; i++) step();

    // Back-to-back: second mult starts in the done cycle of the first
    idle_inputs();
    e_md_start = 1'b1; e_md_op = 2'b01;
    step();
    e_md_start = 1'b0;
    k = cyc;
    guard = 0;
    while (cyc != done_c && guard < 20) begin
      step();
      guard++;
    end
    chk("b2b_done_reached", 1'b1, (cyc == done_c) ? 1'b1 : 1'b0);
    e_md_start = 1'b1; e_md_op = 2'b00;
    step();
    e_md_start = 1'b0;
    for (int i = 0; i < 8; i++) step();

    // Randomized phase
    for (int i = 0; i < 500; i++) begin
      rst       = ($urandom_range(0, 59) == 0);
      d_rs_addr = 5'($urandom_range(0, 3));
      d_rt_addr = 5'($urandom_range(0, 3));
      d_rs_tuse = 2'($urandom_range(0, 3));
      d_rt_tuse = 2'($urandom_range(0, 3));
      d_is_md   = 1'($urandom_range(0, 1));
      e_wa      = 5'($urandom_range(0, 3));
      e_tnew    = 2'($urandom_range(0, 2));
      m_wa      = 5'($urandom_range(0, 3));
      m_tnew    = 2'($urandom_range(0, 2));
      e_md_op   = 2'($urandom_range(0, 3));
      e_md_start = !m_busy(cyc) && ($urandom_range(0, 3) == 0);
      step();
    end

    rst = 1'b0;
    idle_inputs();
    step();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/pipe_stall_ctrl.md
Name: pipe_stall_ctrl

Overview:
Central stall/bubble controller for the 5-stage MIPS pipeline.
- Detects register read-after-write hazards that forwarding cannot resolve, using the Tuse/Tnew scheme.
- Owns the busy counter of the multi-cycle mult/div unit.
- Drives the enable of the PC and F/D registers and the clear of the D/E register. E/M and M/W registers are never stalled.

Parameters:
MULT_CYC, 5, busy cycles for mult/multu (1..15)
DIV_CYC, 10, busy cycles for div/divu (1..15)

Ports:
clk  in  1  clock
rst  in  1  reset
d_rs_addr  in  5  rs index of instruction in D
d_rt_addr  in  5  rt index of instruction in D
d_rs_tuse  in  2  cycles until D instr needs rs (3 = not used)
d_rt_tuse  in  2  cycles until D instr needs rt (3 = not used)
d_is_md  in  1  D instr is mult/multu/div/divu/mfhi/mflo/mthi/mtlo
e_wa  in  5  destination register of instr in E (0 = none)
e_tnew  in  2  cycles until E result is forwardable (0 = ready)
m_wa  in  5  destination register of instr in M
m_tnew  in  2  cycles until M result is forwardable
e_md_start  in  1  E instr is mult/multu/div/divu this cycle
e_md_op  in  2  00 mult, 01 multu, 10 div, 11 divu
stall  out  1  pipeline stall (combinational)
pc_en  out  1  PC write enable, equals ~stall
fd_en  out  1  F/D register enable, equals ~stall
de_clr  out  1  D/E register synchronous clear (bubble), equals stall
md_busy  out  1  mult/div unit busy (registered)
md_done  out  1  one-cycle pulse: HI/LO result valid (registered)

Behaviour:
Reset:
- Synchronous, active-high: reset rst, synchronous, active-high; clock clk.
- On rst: state IDLE, cnt=0, md_busy=0, md_done=0.
- Combinational outputs follow their inputs even during reset.

Register hazard (combinational):
- rs_stall = (d_rs_addr!=0) && ((d_rs_addr==e_wa && e_tnew>d_rs_tuse) || (d_rs_addr==m_wa && m_tnew>d_rs_tuse)).
- rt_stall is identical with rt fields.
- Tuse=3 can never stall because Tnew ≤ 2.
- Register $0 never stalls, even if e_wa/m_wa = 0.

MD hazard (combinational):
- md_stall = d_is_md && (e_md_start || md_busy).

Stall outputs:
- stall = rs_stall | rt_stall | md_stall.
- pc_en = fd_en = ~stall; de_clr = stall. All are combinational, with no added latency.

MD state machine: 4-bit counter cnt, states IDLE and BUSY.
- IDLE, e_md_start=1 at edge k: load cnt = (e_md_op[1] ? DIV_CYC : MULT_CYC), go to BUSY, md_busy=1 from cycle k+1.
- BUSY: cnt decrements each edge. When cnt==1 at an edge, go to IDLE: md_busy=0, md_done=1 for exactly one cycle.
- Net timing: md_busy is high for exactly LAT cycles (k+1..k+LAT); md_done is high in cycle k+LAT+1 only.
- e_md_start while BUSY is illegal, because md_stall prevents it. The controller ignores it (counter is not reloaded). The bench flags it with an assertion.
- e_md_start in the same cycle that md_done is high is legal and starts a new operation normally.

Other rules:
- md_done is 0 in all cycles other than the completion cycle.
- rst asserted mid-operation aborts it: no md_done pulse, md_busy=0 next cycle.
- Simultaneous register and MD hazards: the single stall is asserted and there is no priority issue.

Test Plan:
- lw $1 in E (e_wa=1, e_tnew=2), D instr addu using $1 (rs_tuse=1) -> stall=1, pc_en=0, de_clr=1. Next cycle with m_wa=1, m_tnew=1 -> stall=0.
- e_wa=0, e_tnew=2, d_rs_addr=0, rs_tuse=0 -> stall=0. Also d_rt_tuse=3 with a matching rt -> stall=0.
- e_md_start, e_md_op=00 at edge k -> md_busy high for cycles k+1..k+5, md_done only at k+6. d_is_md=1 throughout -> stall=1 in cycles k..k+5, 0 at k+6.
- e_md_start, e_md_op=10 -> md_busy for 10 cycles. A D instr with d_is_md=0 and no register hazard -> stall=0 throughout.
- Start div, assert rst in the 4th busy cycle -> md_busy=0 next cycle, md_done never pulses, stall drops if no other hazard.
- Back-to-back: a new mult starts in the md_done cycle -> md_busy is re-asserted the next cycle for 5 cycles, with one md_done pulse per operation.
